// File: rtl/spi_bus_arbiter.sv
// rtl/spi_bus_arbiter.sv - round-robin owner of the shared LCD SPI pins with release gap and watchdog
module spi_bus_arbiter #(
    parameter int N          = 4,
    parameter int IDX_W      = 2,
    parameter int GAP_CYCLES = 2,
    parameter int TIMEOUT    = 27_000_000,
    parameter int TO_W       = 25
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [N-1:0]     i_req,
    input  logic [N-1:0]     i_done,
    input  logic [N-1:0]     i_mosi,
    input  logic [N-1:0]     i_dc,
    input  logic [N-1:0]     i_cs,
    output logic [N-1:0]     o_gnt,
    output logic [IDX_W-1:0] o_owner,
    output logic             o_busy,
    output logic             o_timeout,
    output logic             o_mosi,
    output logic             o_dc,
    output logic             o_cs
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

    state_t            state_q, state_d;
    logic [N-1:0]      gnt_q, gnt_d;
    logic [IDX_W-1:0]  owner_q, owner_d;
    logic [TO_W-1:0]   wd_q, wd_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic              timeout_q, timeout_d;

    logic [IDX_W-1:0]  pick;
    logic              pick_vld;
    logic [IDX_W-1:0]  cand;
    logic              done_own;
    logic              own_mosi, own_dc, own_cs;
    logic              wd_expired;

    // Search starts just past the previous owner so it gets lowest priority.
    always_comb begin
        pick     = '0;
        pick_vld = 1'b0;
        cand     = '0;
        for (int k = 1; k <= N; k++) begin
            cand = IDX_W'((int'(owner_q) + k) % N);
            if (!pick_vld && i_req[cand]) begin
                pick     = cand;
                pick_vld = 1'b1;
            end
        end
    end

    always_comb begin
        done_own = 1'b0;
        own_mosi = 1'b0;
        own_dc   = 1'b0;
        own_cs   = 1'b1;
        for (int i = 0; i < N; i++) begin
            if (owner_q == IDX_W'(i)) begin
                done_own = i_done[i];
                own_mosi = i_mosi[i];
                own_dc   = i_dc[i];
                own_cs   = i_cs[i];
            end
        end
    end

    assign wd_expired = (TIMEOUT != 0) && (wd_q == TO_LAST);

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        owner_d   = owner_q;
        wd_d      = wd_q;
        gap_d     = gap_q;
        timeout_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pick_vld) begin
                    owner_d = pick;
                    gnt_d   = N'(1) << pick;
                    wd_d    = '0;
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                // A done in the expiry cycle is a normal release, not a timeout.
                if (done_own) begin
                    gnt_d   = '0;
                    gap_d   = '0;
                    state_d = ST_GAP;
                end else if (wd_expired) begin
                    timeout_d = 1'b1;
                    gnt_d     = '0;
                    gap_d     = '0;
                    state_d   = ST_GAP;
                end else begin
                    wd_d = wd_q + TO_W'(1);
                end
            end
            ST_GAP: begin
                if (gap_q == GAP_LAST) begin
                    gap_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            default: begin
                gnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= ST_IDLE;
            gnt_q     <= '0;
            owner_q   <= IDX_W'(N - 1);
            wd_q      <= '0;
            gap_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            owner_q   <= owner_d;
            wd_q      <= wd_d;
            gap_q     <= gap_d;
            timeout_q <= timeout_d;
        end
    end

    // Pins follow registered state, so reset parks CS high without a clock edge.
    assign o_mosi    = (state_q == ST_GRANT) ? own_mosi : 1'b0;
    assign o_dc      = (state_q == ST_GRANT) ? own_dc   : 1'b0;
    assign o_cs      = (state_q == ST_GRANT) ? own_cs   : 1'b1;
    assign o_gnt     = gnt_q;
    assign o_owner   = owner_q;
    assign o_busy    = (state_q != ST_IDLE);
    assign o_timeout = timeout_q;

endmodule
